// File: rtl/gpio_capture.sv
// GPIO input capture: synchronize, debounce, flag enabled edges into sticky W1C bits, level irq.
// Reads return registered data one cycle after rd_en; no backpressure, every access completes in one cycle.
module gpio_capture #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_i,
  input  logic [1:0]       addr,
  input  logic             wr_en,
  input  logic [31:0]      wdata,
  input  logic             rd_en,
  output logic [31:0]      rdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0][CW-1:0]          r_cnt;
  logic [WIDTH-1:0]                  r_stable;
  logic [WIDTH-1:0]                  r_edge;
  logic [WIDTH-1:0]                  r_mask;
  logic [WIDTH-1:0]                  r_rise;
  logic [WIDTH-1:0]                  r_fall;
  logic [31:0]                       r_rdata;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_stable_nxt;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_sel;
  logic             w_unused_wdata;

  assign w_sync         = r_sync[SYNC_STAGES-1];
  assign w_unused_wdata = &{1'b0, wdata};

  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = (w_sync[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
    end
    w_stable_nxt = r_stable ^ w_accept;
    w_set        = w_accept & ((w_stable_nxt & r_rise) | (~w_stable_nxt & r_fall));
    w_clr        = (wr_en && (addr == 2'd1)) ? wdata[WIDTH-1:0] : '0;
  end

  always_comb begin
    w_rd_sel = '0;
    case (addr)
      2'd0: w_rd_sel[WIDTH-1:0] = r_stable;
      2'd1: w_rd_sel[WIDTH-1:0] = r_edge;
      2'd2: w_rd_sel[WIDTH-1:0] = r_mask;
      default: begin
        w_rd_sel[WIDTH-1:0]   = r_rise;
        w_rd_sel[WIDTH+15:16] = r_fall;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      if (SYNC_STAGES > 1) begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_i};
      end
      for (int i = 0; i < WIDTH; i++) begin
        // Any agreement with the stable level restarts the run of differing cycles.
        if ((w_sync[i] == r_stable[i]) || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
      r_stable <= w_stable_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_edge  <= '0;
      r_mask  <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_rdata <= '0;
    end else begin
      // A new edge in the same cycle as its clear keeps the flag.
      r_edge <= (r_edge & ~w_clr) | w_set;
      if (wr_en && (addr == 2'd2)) begin
        r_mask <= wdata[WIDTH-1:0];
      end
      if (wr_en && (addr == 2'd3)) begin
        r_rise <= wdata[WIDTH-1:0];
        r_fall <= wdata[WIDTH+15:16];
      end
      if (rd_en) begin
        r_rdata <= w_rd_sel;
      end
    end
  end

  assign rdata = r_rdata;
  assign irq   = |(r_edge & r_mask);

endmodule

// File: tb/tb_gpio_capture.sv
// Randomized and directed bench for gpio_capture against a window-based reference model.
module tb_gpio_capture;
  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int H    = SYNC + DEB;

  logic         clk;
  logic         rst;
  logic [W-1:0] gpio_i;
  logic [1:0]   addr;
  logic         wr_en;
  logic [31:0]  wdata;
  logic         rd_en;
  logic [31:0]  rdata;
  logic         irq;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_capture #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .gpio_i(gpio_i), .addr(addr), .wr_en(wr_en),
    .wdata(wdata), .rd_en(rd_en), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference: a level is accepted once the last DEB synchronized samples all disagree with it;
  // the synchronized sample seen at an edge is the raw input sampled SYNC edges earlier.
  logic [W-1:0] m_hist [H];
  logic [W-1:0] m_stable, m_edge, m_mask, m_rise, m_fall;
  logic [W-1:0] m_diff, m_nst, m_set, m_clr;
  logic [31:0]  m_rdata;
  logic         m_irq;

  always_comb begin
    m_diff = '1;
    for (int k = SYNC - 1; k <= H - 2; k++) m_diff = m_diff & (m_hist[k] ^ m_stable);
    m_nst = m_stable ^ m_diff;
    m_set = m_diff & ((m_nst & m_rise) | (~m_nst & m_fall));
    m_clr = (wr_en && addr == 2'd1) ? wdata[W-1:0] : '0;
    m_irq = |(m_edge & m_mask);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < H; k++) m_hist[k] <= '0;
      m_stable <= '0; m_edge <= '0; m_mask <= '0; m_rise <= '0; m_fall <= '0; m_rdata <= '0;
    end else begin
      m_hist[0] <= gpio_i;
      for (int k = 1; k < H; k++) m_hist[k] <= m_hist[k-1];
      m_stable <= m_nst;
      m_edge   <= (m_edge & ~m_clr) | m_set;
      if (wr_en && addr == 2'd2) m_mask <= wdata[W-1:0];
      if (wr_en && addr == 2'd3) begin
        m_rise <= wdata[W-1:0];
        m_fall <= wdata[W+15:16];
      end
      if (rd_en) begin
        case (addr)
          2'd0:    m_rdata <= {24'h0, m_stable};
          2'd1:    m_rdata <= {24'h0, m_edge};
          2'd2:    m_rdata <= {24'h0, m_mask};
          default: m_rdata <= {8'h0, m_fall, 8'h0, m_rise};
        endcase
      end
    end
  end

  // Drive one cycle of inputs from a negedge, return at the following negedge.
  task automatic step(input logic [W-1:0] g, input logic w, input logic [1:0] a,
                      input logic [31:0] d, input logic r);
    gpio_i = g; wr_en = w; addr = a; wdata = d; rd_en = r;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic apply_reset(input logic [W-1:0] g);
    gpio_i = g; wr_en = 1'b0; rd_en = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    gpio_i = 8'h0F; wr_en = 0; rd_en = 0; addr = 0; wdata = 0;
    #1 rst = 1'b0;
    #2;
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(8'h0F, 0, 2'd0, 0, 1);
      n_cmp++; if (rdata !== m_rdata) begin n_bad++; $display("FAIL reset_data_model k=%0d: got %h want %h", k, rdata, m_rdata); end
      if (k == 6 || k == 7) begin
        n_cmp++;
        if (rdata !== ((k == 7) ? 32'h0F : 32'h0)) begin
          n_bad++; $display("FAIL reset_data_latency k=%0d: got %h want %h", k, rdata, (k == 7) ? 32'h0F : 32'h0);
        end
      end
    end
    step(8'h0F, 0, 2'd1, 0, 1);
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_edge: got %h want 0", rdata); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_edge_irq: got %b want 0", irq); end
  endtask

  task automatic test_rise_irq;
    apply_reset(8'h00);
    step(8'h00, 1, 2'd3, 32'h1, 0);
    step(8'h00, 1, 2'd2, 32'h1, 0);
    for (int k = 1; k <= 8; k++) begin
      step(8'h01, 0, 2'd1, 0, 1);
      n_cmp++; if (irq !== m_irq) begin n_bad++; $display("FAIL rise_irq_model k=%0d: got %b want %b", k, irq, m_irq); end
      if (k == 5 || k == 6) begin
        n_cmp++;
        if (irq !== (k == 6)) begin n_bad++; $display("FAIL rise_irq_latency k=%0d: got %b want %b", k, irq, k == 6); end
      end
    end
    step(8'h01, 1, 2'd1, 32'h1, 0);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rise_w1c_irq: got %b want 0", irq); end
    step(8'h01, 0, 2'd1, 0, 1);
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rise_w1c_edge: got %h want 0", rdata); end
  endtask

  task automatic test_glitch;
    apply_reset(8'h00);
    step(8'h00, 1, 2'd3, 32'h00FF00FF, 0);
    step(8'h00, 1, 2'd2, 32'hFF, 0);
    for (int k = 0; k < 3; k++) step(8'h02, 0, 2'd0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(8'h00, 0, 2'd0, 0, 1);
      n_cmp++; if (rdata[1] !== 1'b0) begin n_bad++; $display("FAIL glitch_data k=%0d: got %h want bit1=0", k, rdata); end
    end
    step(8'h00, 0, 2'd1, 0, 1);
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL glitch_edge: got %h want 0", rdata); end
  endtask

  task automatic test_fall;
    apply_reset(8'h0F);
    for (int k = 0; k < 10; k++) step(8'h0F, 0, 2'd0, 0, 0);
    step(8'h0F, 0, 2'd1, 0, 1);
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL fall_no_release_edge: got %h want 0", rdata); end
    step(8'h0F, 1, 2'd3, 32'h00FF0000, 0);
    step(8'h0F, 1, 2'd2, 32'hFF, 0);
    for (int k = 0; k < 10; k++) step(8'h00, 0, 2'd0, 0, 0);
    step(8'h00, 0, 2'd1, 0, 1);
    n_cmp++; if (rdata !== 32'h0F) begin n_bad++; $display("FAIL fall_edge: got %h want 0000000f", rdata); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL fall_irq: got %b want 1", irq); end
  endtask

  task automatic test_w1c_collision;
    apply_reset(8'h00);
    step(8'h00, 1, 2'd3, 32'h00010001, 0);
    for (int k = 0; k < 8; k++) step(8'h01, 0, 2'd0, 0, 0);
    step(8'h01, 1, 2'd1, 32'h1, 0);
    step(8'h01, 0, 2'd1, 0, 1);
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL collide_preclear: got %h want 0", rdata); end
    for (int k = 1; k <= 6; k++) step(8'h00, (k == 6), 2'd1, 32'h1, 0);
    step(8'h00, 0, 2'd1, 0, 1);
    n_cmp++; if (rdata !== 32'h1) begin n_bad++; $display("FAIL collide_set_wins: got %h want 00000001", rdata); end
  endtask

  task automatic test_reset_mid;
    apply_reset(8'h00);
    step(8'h00, 1, 2'd2, 32'hFF, 0);
    step(8'h00, 1, 2'd3, 32'hFF, 0);
    for (int k = 0; k < 8; k++) step(8'h01, 0, 2'd0, 0, 0);
    step(8'h01, 0, 2'd2, 0, 1);
    n_cmp++; if (rdata !== 32'hFF || irq !== 1'b1) begin n_bad++; $display("FAIL midrst_setup: got %h/%b want 000000ff/1", rdata, irq); end
    for (int k = 0; k < 4; k++) step(8'h03, 0, 2'd0, 0, 0);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL midrst_rdata: got %h want 0", rdata); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL midrst_irq: got %b want 0", irq); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(8'h03, 0, 2'd0, 0, 1);
      n_cmp++; if (rdata !== m_rdata) begin n_bad++; $display("FAIL midrst_model k=%0d: got %h want %h", k, rdata, m_rdata); end
      if (k == 6 || k == 7) begin
        n_cmp++;
        if (rdata !== ((k == 7) ? 32'h03 : 32'h0)) begin
          n_bad++; $display("FAIL midrst_latency k=%0d: got %h want %h", k, rdata, (k == 7) ? 32'h03 : 32'h0);
        end
      end
    end
  endtask

  task automatic test_rd_wr_same;
    apply_reset(8'h00);
    step(8'h00, 1, 2'd2, 32'hAA, 0);
    step(8'h00, 1, 2'd2, 32'h55, 1);
    n_cmp++; if (rdata !== 32'hAA) begin n_bad++; $display("FAIL rdwr_prewrite: got %h want 000000aa", rdata); end
    step(8'h00, 0, 2'd2, 0, 1);
    n_cmp++; if (rdata !== 32'h55) begin n_bad++; $display("FAIL rdwr_postwrite: got %h want 00000055", rdata); end
    step(8'h00, 1, 2'd3, 32'hFFFFFFFF, 0);
    step(8'h00, 0, 2'd3, 0, 1);
    n_cmp++; if (rdata !== 32'h00FF00FF) begin n_bad++; $display("FAIL mode_reserved: got %h want 00ff00ff", rdata); end
    step(8'h00, 1, 2'd0, 32'hFFFFFFFF, 0);
    step(8'h00, 0, 2'd0, 0, 1);
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL data_write_ignored: got %h want 0", rdata); end
    step(8'h00, 0, 2'd0, 0, 0);
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rdata_hold: got %h want 0", rdata); end
  endtask

  task automatic test_random;
    logic [W-1:0] g;
    int hold;
    g = W'($urandom);
    hold = 0;
    apply_reset(g);
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        g = g ^ W'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      step(g, ($urandom_range(0, 4) == 0), 2'($urandom), $urandom, $urandom_range(0, 1) == 1);
      n_cmp++; if (rdata !== m_rdata) begin n_bad++; $display("FAIL rand_rdata c=%0d: got %h want %h", c, rdata, m_rdata); end
      n_cmp++; if (irq !== m_irq) begin n_bad++; $display("FAIL rand_irq c=%0d: got %b want %b", c, irq, m_irq); end
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    gpio_i = '0; addr = '0; wr_en = 1'b0; wdata = '0; rd_en = 1'b0;
    test_reset();
    test_rise_irq();
    test_glitch();
    test_fall();
    test_w1c_collision();
    test_reset_mid();
    test_rd_wr_same();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_capture.md
GPIO_CAPTURE -- requirements
Module: gpio_capture

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of GPIO input bits; legal range is 1..16.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the depth of the input synchronizer flops; minimum is 2.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the consecutive stable cycles required to accept a change; minimum is 1, and 1 means no filtering.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-005 clk  input  1  Rising-edge clock for all state.
REQ-006 rst  input  1  Asynchronous active-low reset.
REQ-007 gpio_i  input  WIDTH  Asynchronous external inputs.
REQ-008 addr  input  2  Register select: 0 = DATA, 1 = EDGE, 2 = MASK, 3 = MODE.
REQ-009 wr_en  input  1  Write strobe, sampled on clk.
REQ-010 wdata  input  32  Write data.
REQ-011 rd_en  input  1  Read strobe, sampled on clk.
REQ-012 rdata  output  32  Registered read data.
REQ-013 irq  output  1  Level interrupt request.

Function
REQ-014 Each gpio_i bit SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is sync[i].
REQ-015 Each bit SHALL own a debounce counter of width clog2(DEBOUNCE_CYCLES)+1 and a stable level stable[i].
- If sync[i]==stable[i] on an edge, the counter SHALL clear to 0.
- If they differ and counter==DEBOUNCE_CYCLES-1, stable[i] SHALL load sync[i] and the counter SHALL clear.
- If they differ otherwise, the counter SHALL increment.
REQ-016 A gpio_i change held steady SHALL appear on stable exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles later; a pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never reach stable.
REQ-017 MODE SHALL hold rise-enable in bits [WIDTH-1:0] and fall-enable in bits [WIDTH+15:16]; all other bits are reserved.
REQ-018 On the cycle stable[i] updates 0->1 with rise-enable[i] set, or 1->0 with fall-enable[i] set, EDGE[i] SHALL set; EDGE bits are sticky.
REQ-019 A write to EDGE SHALL clear each bit where wdata is 1 (write-1-to-clear).
- If a clear and a set hit the same bit in the same cycle, set SHALL win.
REQ-020 Writes to MASK SHALL load wdata[WIDTH-1:0]; writes to MODE SHALL load the defined bits; writes to DATA SHALL be ignored.
REQ-021 irq SHALL equal |(EDGE & MASK) as a function of registered state only, with no combinational path from wdata or gpio_i.
REQ-022 When rd_en is high on an edge, rdata SHALL load the register at addr, zero-extended, one cycle after the request; DATA returns stable.
- When rd_en is low, rdata SHALL hold its value.
REQ-023 If rd_en and wr_en target the same register in one cycle, rdata SHALL return the pre-write value.
REQ-024 Reserved and unused rdata bits SHALL read 0.

Reset
REQ-025 While rst is low, all sync flops, stable, counters, EDGE, MASK, MODE and rdata SHALL be 0 and irq SHALL be 0, independent of clk.
REQ-026 Reset asserted mid-debounce SHALL discard the pending count; after release, debounce SHALL restart from 0 against stable=0.
REQ-027 Because MODE resets to 0, inputs already high at reset release SHALL update stable but SHALL NOT set EDGE.

Verification
REQ-028 Defaults, gpio_i=8'h0F held through reset release -> DATA reads 0x0F from cycle 6 onward; EDGE=0; irq=0.
REQ-029 MODE=0x0001, MASK=0x01, bit0 0->1 -> EDGE=0x01 and irq=1 six cycles later; write EDGE=0x01 -> EDGE=0 and irq=0 the next cycle.
REQ-030 Bit1 pulsed high for 3 cycles -> DATA bit1 stays 0 and EDGE stays 0.
REQ-031 MODE=0x00FF0000, gpio_i 0x0F->0x00 -> EDGE=0x0F, with no rising flags set.
REQ-032 W1C of EDGE bit0 on the exact cycle a new bit0 edge is accepted -> EDGE bit0 remains 1.
REQ-033 rst dropped while a counter is at 2 -> all outputs are 0 immediately; after release, a full SYNC_STAGES+DEBOUNCE_CYCLES delay is needed again.
